meteor_spawn_scheduler: RTL
===========================

METEOR_SPAWN_SCHEDULER -- requirements
Module: meteor_spawn_scheduler

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  N_SLOTS, 8, number of meteor slots in the meteor datapath.
  LEVEL_FRAMES, 600, frames per difficulty level.
  BASE_INTERVAL, 60, spawn interval in frames at level 0.
  INTERVAL_STEP, 5, interval reduction per level.
  MIN_INTERVAL, 10, interval floor in frames.
  MAX_LEVEL, 7, level saturation value.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  Clk  in  1  system clock; the block's only clock.
  Reset  in  1  asynchronous, active-high reset.
  game_active  in  1  high while the game screen is shown.
  frame_tick  in  1  one-cycle pulse per video frame.
  slot_busy  in  N_SLOTS  bit i high = meteor slot i occupied.
  spawn_ready  in  1  meteor datapath accepts a spawn.
  spawn_valid  out  1  spawn request pending.
  spawn_slot  out  3  target slot index.
  spawn_x  out  10  meteor start x, range 0..607.
  spawn_speed  out  3  meteor fall speed, range 1..7.
  level  out  3  current difficulty level.
  dropped_cnt  out  8  saturating count of spawns skipped because all slots were busy.

Function
REQ-003 States SHALL be IDLE, WAIT, PICK and ISSUE.
REQ-004 IDLE: outputs SHALL be 0 and counters SHALL be held at 0; on game_active=1 the state SHALL go to WAIT on the next cycle.
REQ-005 In any non-IDLE state, game_active=0 SHALL force IDLE on the next edge, abort any pending spawn and clear all counters except dropped_cnt.
REQ-006 cur_interval SHALL be max(BASE_INTERVAL - level*INTERVAL_STEP, MIN_INTERVAL), computed in 8-bit unsigned arithmetic with no underflow.
REQ-007 WAIT: each frame_tick SHALL increment interval_cnt; the tick on which interval_cnt==cur_interval-1 SHALL clear interval_cnt and move to PICK.
REQ-008 interval_cnt SHALL count only in WAIT and SHALL be 0 on every entry to WAIT.
REQ-009 In all non-IDLE states, each frame_tick SHALL increment level_frame_cnt; at LEVEL_FRAMES-1 it SHALL wrap to 0 and level SHALL increment, saturating at MAX_LEVEL.
REQ-010 PICK SHALL last exactly one cycle and SHALL select the lowest-index slot with slot_busy=0.
REQ-011 PICK with no free slot SHALL increment dropped_cnt (saturating at 255) and return to WAIT.
REQ-012 PICK with a free slot SHALL register spawn_slot, spawn_x = r if r<608 else r-608 where r=lfsr[9:0], and spawn_speed = min(1+level+lfsr[10], 7), then move to ISSUE.
REQ-013 ISSUE SHALL drive spawn_valid=1 with slot, x and speed held stable until spawn_valid&&spawn_ready; on that cycle the state SHALL return to WAIT.
REQ-014 spawn_ready while spawn_valid=0 SHALL be ignored.
REQ-015 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL step every cycle in all states and SHALL never reach state 0.
REQ-016 The level-increment tick and the interval-expiry tick on the same cycle SHALL both take effect; the new level SHALL apply to the next interval.

Reset
REQ-017 Reset SHALL asynchronously force IDLE, all counters and outputs to 0, level to 0, dropped_cnt to 0 and the LFSR to 16'hACE1.
REQ-018 Reset asserted during ISSUE SHALL drop spawn_valid immediately, without waiting for a clock edge.

Structure
REQ-019 The shared package game_pkg SHALL hold the state enum sched_state_t and the constants SCREEN_W=640, METEOR_W=32 and N_SLOTS.
REQ-020 The LFSR SHALL be a sub-module named lfsr16 with ports Clk, Reset, enable and q[15:0].

Verification
REQ-021 Start game, slot_busy=0, spawn_ready=1 -> first spawn_valid in the cycle after PICK following the 60th frame_tick, spawn_slot=0, spawn_speed in 1..2.
REQ-022 slot_busy=8'b0000_0111 at PICK -> spawn_slot=3.
REQ-023 slot_busy=8'hFF for 3 intervals -> dropped_cnt=3 and spawn_valid never asserts.
REQ-024 spawn_ready=0 for 20 cycles in ISSUE -> spawn_valid, spawn_slot and spawn_x are stable throughout; one spawn only after ready.
REQ-025 Run 600*12 frames -> level=7 (saturated) and interval=25 frames at level 7.
REQ-026 game_active dropped mid-ISSUE, and async Reset pulse between edges -> spawn_valid=0 next cycle or immediately respectively, state IDLE, level=0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions for the meteor spawn scheduler: FSM state encoding,
// screen geometry and the spawn-position wrap helper.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    PICK  = 2'd2,
    ISSUE = 2'd3
  } sched_state_t;

  localparam int SCREEN_W = 640;
  localparam int METEOR_W = 32;
  localparam int N_SLOTS  = 8;
  localparam int X_RANGE  = SCREEN_W - METEOR_W;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Folds a 10-bit random value onto the legal meteor start range 0..X_RANGE-1.
  function automatic logic [9:0] wrap_x(input logic [9:0] raw);
    logic [9:0] lim;
    lim = 10'(X_RANGE);
    if (raw < lim) begin
      wrap_x = raw;
    end else begin
      wrap_x = raw - lim;
    end
  endfunction

endpackage

// File: rtl/meteor_spawn_scheduler_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) seeded with LFSR_SEED on reset.
module lfsr16
  import game_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        enable,
  output logic [15:0] q
);

  logic [15:0] r_q;
  logic        w_fb;
  logic [15:0] w_next;

  assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];

  // The all-zero lockup state is unreachable from a non-zero seed; reseed anyway if upset.
  always_comb begin
    w_next = {r_q[14:0], w_fb};
    if (w_next == 16'h0000) begin
      w_next = LFSR_SEED;
    end else begin
      w_next = {r_q[14:0], w_fb};
    end
  end

  // Shift register state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_q <= LFSR_SEED;
    end else if (enable) begin
      r_q <= w_next;
    end else begin
      r_q <= r_q;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/meteor_spawn_scheduler.sv
// Meteor spawn scheduler: paces spawns by a level-dependent frame interval,
// picks the lowest free slot and hands a randomised spawn to the meteor datapath.
module meteor_spawn_scheduler #(
  parameter int N_SLOTS       = 8,
  parameter int LEVEL_FRAMES  = 600,
  parameter int BASE_INTERVAL = 60,
  parameter int INTERVAL_STEP = 5,
  parameter int MIN_INTERVAL  = 10,
  parameter int MAX_LEVEL     = 7
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               game_active,
  input  logic               frame_tick,
  input  logic [N_SLOTS-1:0] slot_busy,
  input  logic               spawn_ready,
  output logic               spawn_valid,
  output logic [2:0]         spawn_slot,
  output logic [9:0]         spawn_x,
  output logic [2:0]         spawn_speed,
  output logic [2:0]         level,
  output logic [7:0]         dropped_cnt
);
  import game_pkg::*;

  localparam int LFW = (LEVEL_FRAMES > 1) ? $clog2(LEVEL_FRAMES) : 1;

  sched_state_t r_state;
  logic [7:0]     r_interval_cnt;
  logic [7:0]     r_interval;
  logic [LFW-1:0] r_level_frame_cnt;
  logic [2:0]     r_level;
  logic [7:0]     r_dropped;
  logic           r_spawn_valid;
  logic [2:0]     r_spawn_slot;
  logic [9:0]     r_spawn_x;
  logic [2:0]     r_spawn_speed;

  logic [15:0] w_lfsr;
  logic        w_level_wrap;
  logic [2:0]  w_level_nxt;
  logic [7:0]  w_step_total;
  logic [7:0]  w_cur_interval;
  logic [7:0]  w_interval_last;
  logic        w_free_found;
  logic [2:0]  w_free_idx;
  logic [3:0]  w_speed_sum;
  logic [2:0]  w_speed;

  lfsr16 u_lfsr (
    .Clk    (Clk),
    .Reset  (Reset),
    .enable (1'b1),
    .q      (w_lfsr)
  );

  // Level tick and the level that will hold after this edge.
  always_comb begin
    w_level_wrap = (r_state != IDLE) && frame_tick &&
                   (r_level_frame_cnt == LFW'(LEVEL_FRAMES - 1));
    if (w_level_wrap && (r_level != 3'(MAX_LEVEL))) begin
      w_level_nxt = r_level + 3'd1;
    end else begin
      w_level_nxt = r_level;
    end
  end

  // Interval for the WAIT period about to start, derived from the post-edge level.
  always_comb begin
    w_step_total = 8'(w_level_nxt) * 8'(INTERVAL_STEP);
    if (w_step_total >= 8'(BASE_INTERVAL)) begin
      w_cur_interval = 8'(MIN_INTERVAL);
    end else if ((8'(BASE_INTERVAL) - w_step_total) < 8'(MIN_INTERVAL)) begin
      w_cur_interval = 8'(MIN_INTERVAL);
    end else begin
      w_cur_interval = 8'(BASE_INTERVAL) - w_step_total;
    end
    if (w_cur_interval == 8'd0) begin
      w_cur_interval = 8'd1;
    end else begin
      w_cur_interval = w_cur_interval;
    end
  end

  // Terminal count of the latched interval.
  always_comb begin
    if (r_interval == 8'd0) begin
      w_interval_last = 8'd0;
    end else begin
      w_interval_last = r_interval - 8'd1;
    end
  end

  // Lowest-index free slot; scanning downwards lets the lowest index win.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = 3'd0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!slot_busy[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = 3'(i);
      end else begin
        w_free_found = w_free_found;
      end
    end
  end

  // Fall speed grows with level plus one random bit, clamped to the datapath max.
  always_comb begin
    w_speed_sum = 4'd1 + {1'b0, r_level} + {3'd0, w_lfsr[10]};
    if (w_speed_sum > 4'd7) begin
      w_speed = 3'd7;
    end else begin
      w_speed = w_speed_sum[2:0];
    end
  end

  // Scheduler FSM with level/interval counters and registered spawn outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state           <= IDLE;
      r_interval_cnt    <= 8'd0;
      r_interval        <= 8'd0;
      r_level_frame_cnt <= '0;
      r_level           <= 3'd0;
      r_dropped         <= 8'd0;
      r_spawn_valid     <= 1'b0;
      r_spawn_slot      <= 3'd0;
      r_spawn_x         <= 10'd0;
      r_spawn_speed     <= 3'd0;
    end else if ((r_state != IDLE) && !game_active) begin
      r_state           <= IDLE;
      r_interval_cnt    <= 8'd0;
      r_interval        <= 8'd0;
      r_level_frame_cnt <= '0;
      r_level           <= 3'd0;
      r_spawn_valid     <= 1'b0;
      r_spawn_slot      <= 3'd0;
      r_spawn_x         <= 10'd0;
      r_spawn_speed     <= 3'd0;
    end else begin
      if ((r_state != IDLE) && frame_tick) begin
        r_level_frame_cnt <= w_level_wrap ? '0 : r_level_frame_cnt + LFW'(1);
        r_level           <= w_level_nxt;
      end else begin
        r_level_frame_cnt <= r_level_frame_cnt;
        r_level           <= r_level;
      end

      case (r_state)
        IDLE: begin
          r_interval_cnt    <= 8'd0;
          r_level_frame_cnt <= '0;
          r_level           <= 3'd0;
          r_spawn_valid     <= 1'b0;
          r_spawn_slot      <= 3'd0;
          r_spawn_x         <= 10'd0;
          r_spawn_speed     <= 3'd0;
          if (game_active) begin
            r_state    <= WAIT;
            r_interval <= w_cur_interval;
          end else begin
            r_state    <= IDLE;
            r_interval <= 8'd0;
          end
        end
        WAIT: begin
          if (frame_tick && (r_interval_cnt == w_interval_last)) begin
            r_interval_cnt <= 8'd0;
            r_state        <= PICK;
          end else if (frame_tick) begin
            r_interval_cnt <= r_interval_cnt + 8'd1;
          end else begin
            r_interval_cnt <= r_interval_cnt;
          end
        end
        PICK: begin
          r_interval_cnt <= 8'd0;
          if (w_free_found) begin
            r_spawn_valid <= 1'b1;
            r_spawn_slot  <= w_free_idx;
            r_spawn_x     <= wrap_x(w_lfsr[9:0]);
            r_spawn_speed <= w_speed;
            r_state       <= ISSUE;
          end else begin
            r_dropped  <= (r_dropped == 8'hFF) ? 8'hFF : r_dropped + 8'd1;
            r_interval <= w_cur_interval;
            r_state    <= WAIT;
          end
        end
        ISSUE: begin
          if (r_spawn_valid && spawn_ready) begin
            r_spawn_valid  <= 1'b0;
            r_interval_cnt <= 8'd0;
            r_interval     <= w_cur_interval;
            r_state        <= WAIT;
          end else begin
            r_spawn_valid <= r_spawn_valid;
            r_state       <= ISSUE;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_spawn_valid <= 1'b0;
        end
      endcase
    end
  end

  assign spawn_valid = r_spawn_valid;
  assign spawn_slot  = r_spawn_slot;
  assign spawn_x     = r_spawn_x;
  assign spawn_speed = r_spawn_speed;
  assign level       = r_level;
  assign dropped_cnt = r_dropped;

endmodule
